lim_mem_sequencer: RTL and testbench

- Two-requester arbiter and transaction sequencer in front of mem_datapath (racetrack LiM memory).
- Accepts standard and logic-in-memory (LiM) load/store requests from port 0 (core LSU) and port 1 (test/DMA).
- Drives the datapath one transaction at a time: one-cycle en_ab pulse, then waits for the r_valid rising edge, then enforces a recovery gap.
- Returns read data and a completion strobe to the granted requester.

---
 rtl/lim_mem_sequencer_pkg.sv | 30 +++
 rtl/lim_rr_arb2.sv | 31 +++
 rtl/lim_mem_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_lim_mem_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lim_mem_sequencer_pkg.sv
// Shared types for the racetrack LiM sequencer: function codes, FSM states and the latched command.
// Optional feature macro used by the top: LIM_SEQ_TIMEOUT_EN.
package racetrack_defines;

    localparam int LIM_ADDR_WIDTH  = 8;
    localparam int LIM_FUNCT_WIDTH = 8;

    localparam logic [LIM_FUNCT_WIDTH-1:0] FUNCT_NULL = 8'd0;
    localparam logic [LIM_FUNCT_WIDTH-1:0] FUNCT_XOR  = 8'd1;
    localparam logic [LIM_FUNCT_WIDTH-1:0] FUNCT_AND  = 8'd2;
    localparam logic [LIM_FUNCT_WIDTH-1:0] FUNCT_OR   = 8'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic [LIM_ADDR_WIDTH-1:0]  addr;
        logic                       we;
        logic [3:0]                 be;
        logic [31:0]                wdata;
        logic [31:0]                mask;
        logic [LIM_FUNCT_WIDTH-1:0] funct;
    } lim_cmd_t;

endpackage

// File: rtl/lim_rr_arb2.sv
// Two-input round-robin arbiter; rr_last remembers the last winner and moves only on i_update.
module lim_rr_arb2
    import racetrack_defines::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_gnt
);

    logic r_rr_last;

    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = r_rr_last ? 2'b01 : 2'b10;
        end
    end

    // Reset to 1 so port 0 wins the first tie.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_last <= 1'b1;
        end else if (i_update) begin
            r_rr_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/lim_mem_sequencer.sv
// Two-port arbiter and one-at-a-time transaction sequencer in front of the racetrack LiM datapath.
// Define LIM_SEQ_TIMEOUT_EN to enable the WAIT watchdog and the pN_err_o reporting.
module lim_mem_sequencer
    import racetrack_defines::*;
#(
    parameter int ADDR_WIDTH     = LIM_ADDR_WIDTH,
    parameter int FUNCT_WIDTH    = LIM_FUNCT_WIDTH,
    parameter int GAP_CYCLES     = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   p0_req_i,
    output logic                   p0_gnt_o,
    input  logic [ADDR_WIDTH-1:0]  p0_addr_i,
    input  logic                   p0_we_i,
    input  logic [3:0]             p0_be_i,
    input  logic [31:0]            p0_wdata_i,
    input  logic [31:0]            p0_mask_i,
    input  logic [FUNCT_WIDTH-1:0] p0_funct_i,
    output logic [31:0]            p0_rdata_o,
    output logic                   p0_rvalid_o,
    output logic                   p0_err_o,
    input  logic                   p1_req_i,
    output logic                   p1_gnt_o,
    input  logic [ADDR_WIDTH-1:0]  p1_addr_i,
    input  logic                   p1_we_i,
    input  logic [3:0]             p1_be_i,
    input  logic [31:0]            p1_wdata_i,
    input  logic [31:0]            p1_mask_i,
    input  logic [FUNCT_WIDTH-1:0] p1_funct_i,
    output logic [31:0]            p1_rdata_o,
    output logic                   p1_rvalid_o,
    output logic                   p1_err_o,
    output logic                   en_ab_o,
    output logic [ADDR_WIDTH-1:0]  ADDR_o,
    output logic [3:0]             be_b_o,
    output logic [31:0]            write_i_data_o,
    output logic                   write_en_data_o,
    output logic [31:0]            mask_o,
    output logic [FUNCT_WIDTH-1:0] funct_o,
    output logic                   range_active_o,
    input  logic [31:0]            r_data_i,
    input  logic                   r_valid_i
);

    seq_state_t r_state;
    lim_cmd_t   r_cmd;
    logic       r_owner;
    logic       r_valid_q;
    logic [31:0] r_data;
    logic [3:0] r_gap_cnt;
    logic       r_p0_rvalid;
    logic       r_p1_rvalid;

    logic [1:0] w_req;
    logic [1:0] w_sel;
    logic       w_grant;
    logic       w_edge;
    lim_cmd_t   w_req_cmd;

    assign w_req   = {p1_req_i, p0_req_i};
    assign w_grant = (r_state == IDLE) && (w_req != 2'b00);
    assign w_edge  = r_valid_i & ~r_valid_q;

    lim_rr_arb2 u_arb (
        .i_clk    (clk_i),
        .i_rst    (rst_i),
        .i_req    (w_req),
        .i_update (w_grant),
        .o_gnt    (w_sel)
    );

    always_comb begin
        w_req_cmd = '{addr: p0_addr_i, we: p0_we_i, be: p0_be_i, wdata: p0_wdata_i,
                      mask: p0_mask_i, funct: p0_funct_i};
        if (w_sel[1]) begin
            w_req_cmd = '{addr: p1_addr_i, we: p1_we_i, be: p1_be_i, wdata: p1_wdata_i,
                          mask: p1_mask_i, funct: p1_funct_i};
        end
    end

`ifdef LIM_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] r_wait_cnt;
    logic            r_err;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cmd       <= '0;
            r_owner     <= 1'b0;
            r_valid_q   <= 1'b0;
            r_data      <= '0;
            r_gap_cnt   <= '0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
`ifdef LIM_SEQ_TIMEOUT_EN
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_valid_q   <= r_valid_i;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_cmd   <= w_req_cmd;
                        r_owner <= w_sel[1];
                        r_data  <= '0;
`ifdef LIM_SEQ_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                        // An all-zero byte enable never touches the datapath.
                        r_state <= (w_req_cmd.be == 4'b0000) ? RESP : ISSUE;
                    end
                end
                ISSUE: begin
`ifdef LIM_SEQ_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (w_edge) begin
                        r_data  <= r_data_i;
                        r_state <= RESP;
                    end
`ifdef LIM_SEQ_TIMEOUT_EN
                    else if (r_wait_cnt == TO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    r_p0_rvalid <= ~r_owner;
                    r_p1_rvalid <= r_owner;
                    r_gap_cnt   <= '0;
                    r_state     <= GAP;
                end
                GAP: begin
                    if (r_gap_cnt == 4'(GAP_CYCLES - 1)) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Grant is combinational off the arbiter, so it must be forced low while reset is held.
    assign p0_gnt_o = ~rst_i & w_grant & w_sel[0];
    assign p1_gnt_o = ~rst_i & w_grant & w_sel[1];

    assign p0_rvalid_o = r_p0_rvalid;
    assign p1_rvalid_o = r_p1_rvalid;
    assign p0_rdata_o  = r_p0_rvalid ? r_data : 32'd0;
    assign p1_rdata_o  = r_p1_rvalid ? r_data : 32'd0;

`ifdef LIM_SEQ_TIMEOUT_EN
    assign p0_err_o = r_p0_rvalid & r_err;
    assign p1_err_o = r_p1_rvalid & r_err;
`else
    assign p0_err_o = 1'b0;
    assign p1_err_o = 1'b0;
`endif

    assign en_ab_o         = (r_state == ISSUE);
    assign ADDR_o          = r_cmd.addr;
    assign be_b_o          = r_cmd.be;
    assign write_i_data_o  = r_cmd.wdata;
    assign write_en_data_o = r_cmd.we;
    assign mask_o          = r_cmd.mask;
    assign funct_o         = r_cmd.funct;
    assign range_active_o  = 1'b0;

endmodule

// File: tb/tb_lim_mem_sequencer.sv
// Directed self-checking bench for lim_mem_sequencer; the timeout scenario runs when LIM_SEQ_TIMEOUT_EN is defined.
module tb_lim_mem_sequencer;
    import racetrack_defines::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        p0_req_i, p1_req_i;
    logic        p0_gnt_o, p1_gnt_o;
    logic [7:0]  p0_addr_i, p1_addr_i;
    logic        p0_we_i, p1_we_i;
    logic [3:0]  p0_be_i, p1_be_i;
    logic [31:0] p0_wdata_i, p1_wdata_i, p0_mask_i, p1_mask_i;
    logic [7:0]  p0_funct_i, p1_funct_i;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic        p0_rvalid_o, p1_rvalid_o, p0_err_o, p1_err_o;
    logic        en_ab_o, write_en_data_o, range_active_o;
    logic [7:0]  ADDR_o, funct_o;
    logic [3:0]  be_b_o;
    logic [31:0] write_i_data_o, mask_o, r_data_i;
    logic        r_valid_i;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    lim_mem_sequencer #(.GAP_CYCLES(1), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .p0_req_i(p0_req_i), .p0_gnt_o(p0_gnt_o), .p0_addr_i(p0_addr_i), .p0_we_i(p0_we_i),
        .p0_be_i(p0_be_i), .p0_wdata_i(p0_wdata_i), .p0_mask_i(p0_mask_i), .p0_funct_i(p0_funct_i),
        .p0_rdata_o(p0_rdata_o), .p0_rvalid_o(p0_rvalid_o), .p0_err_o(p0_err_o),
        .p1_req_i(p1_req_i), .p1_gnt_o(p1_gnt_o), .p1_addr_i(p1_addr_i), .p1_we_i(p1_we_i),
        .p1_be_i(p1_be_i), .p1_wdata_i(p1_wdata_i), .p1_mask_i(p1_mask_i), .p1_funct_i(p1_funct_i),
        .p1_rdata_o(p1_rdata_o), .p1_rvalid_o(p1_rvalid_o), .p1_err_o(p1_err_o),
        .en_ab_o(en_ab_o), .ADDR_o(ADDR_o), .be_b_o(be_b_o), .write_i_data_o(write_i_data_o),
        .write_en_data_o(write_en_data_o), .mask_o(mask_o), .funct_o(funct_o),
        .range_active_o(range_active_o), .r_data_i(r_data_i), .r_valid_i(r_valid_i)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        p0_req_i = 1'b1;
        p0_be_i = 4'hF;
        p0_addr_i = 8'h55;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        checks++; if (p0_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", p0_gnt_o); end
        checks++; if (en_ab_o !== 1'b0) begin errors++; $display("FAIL reset_en_ab: got %b want 0", en_ab_o); end
        checks++; if (ADDR_o !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", ADDR_o); end
        checks++; if (be_b_o !== 4'h0) begin errors++; $display("FAIL reset_be: got %h want 0", be_b_o); end
        checks++; if (write_en_data_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", write_en_data_o); end
        checks++; if ({p0_rvalid_o, p1_rvalid_o, p0_err_o, p1_err_o} !== 4'b0) begin
            errors++; $display("FAIL reset_rvalid: got %b want 0000", {p0_rvalid_o, p1_rvalid_o, p0_err_o, p1_err_o});
        end
        checks++; if (range_active_o !== 1'b0) begin errors++; $display("FAIL reset_range: got %b want 0", range_active_o); end
        p0_req_i = 1'b0;
        rst_i = 1'b0;
        tick();
    endtask

    // Both ports hold req for four transactions; grants must alternate p0, p1, p0, p1.
    task automatic test_back_to_back;
        bit found;
        bit gp;
        logic [31:0] d;
        p0_addr_i = 8'h10; p0_we_i = 1'b1; p0_be_i = 4'hF; p0_wdata_i = 32'h1111; p0_funct_i = FUNCT_NULL;
        p1_addr_i = 8'h20; p1_we_i = 1'b0; p1_be_i = 4'hF; p1_wdata_i = 32'h2222; p1_funct_i = FUNCT_NULL;
        p0_req_i = 1'b1; p1_req_i = 1'b1;
        for (int n = 0; n < 4; n++) begin
            d = 32'hA000_0000 + 32'(n);
            found = 1'b0;
            for (int c = 0; c < 16; c++) begin
                @(negedge clk_i);
                if (p0_gnt_o || p1_gnt_o) begin found = 1'b1; break; end
            end
            checks++; if (!found) begin errors++; $display("FAIL b2b_gnt_timeout: txn %0d got no grant want one", n); end
            gp = p1_gnt_o;
            checks++; if ({p1_gnt_o, p0_gnt_o} !== (n[0] ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL b2b_order: txn %0d got gnt %b want %b", n, {p1_gnt_o, p0_gnt_o}, n[0] ? 2'b10 : 2'b01);
            end
            tick();
            @(negedge clk_i);
            checks++; if (en_ab_o !== 1'b1 || ADDR_o !== (gp ? 8'h20 : 8'h10)) begin
                errors++; $display("FAIL b2b_issue: txn %0d got en_ab %b addr %h want 1 %h", n, en_ab_o, ADDR_o, gp ? 8'h20 : 8'h10);
            end
            tick();
            r_data_i = d; r_valid_i = 1'b1;
            tick();
            r_valid_i = 1'b0;
            tick();
            if (n == 3) begin p0_req_i = 1'b0; p1_req_i = 1'b0; end
            @(negedge clk_i);
            checks++; if ({p1_rvalid_o, p0_rvalid_o} !== (gp ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL b2b_rvalid: txn %0d got %b want %b", n, {p1_rvalid_o, p0_rvalid_o}, gp ? 2'b10 : 2'b01);
            end
            checks++; if ((gp ? p1_rdata_o : p0_rdata_o) !== d) begin
                errors++; $display("FAIL b2b_rdata: txn %0d got %h want %h", n, gp ? p1_rdata_o : p0_rdata_o, d);
            end
        end
        tick();
    endtask

    task automatic test_single_store;
        p0_addr_i = 8'h04; p0_wdata_i = 32'h349B; p0_be_i = 4'hF; p0_we_i = 1'b1;
        p0_funct_i = FUNCT_NULL; p0_mask_i = 32'h0;
        p0_req_i = 1'b1;
        @(negedge clk_i);
        checks++; if (p0_gnt_o !== 1'b1 || p1_gnt_o !== 1'b0 || en_ab_o !== 1'b0) begin
            errors++; $display("FAIL store_gnt: got gnt0 %b gnt1 %b en_ab %b want 1 0 0", p0_gnt_o, p1_gnt_o, en_ab_o);
        end
        tick();
        p0_req_i = 1'b0;
        @(negedge clk_i);
        checks++; if (en_ab_o !== 1'b1) begin errors++; $display("FAIL store_en_ab: got %b want 1", en_ab_o); end
        checks++; if (ADDR_o !== 8'h04 || write_en_data_o !== 1'b1 || write_i_data_o !== 32'h349B || be_b_o !== 4'hF) begin
            errors++; $display("FAIL store_cmd: got addr %h we %b wdata %h be %h want 04 1 0000349b f",
                               ADDR_o, write_en_data_o, write_i_data_o, be_b_o);
        end
        tick();
        r_data_i = 32'hCAFE_0001; r_valid_i = 1'b1;
        @(negedge clk_i);
        checks++; if (en_ab_o !== 1'b0) begin errors++; $display("FAIL store_en_ab_pulse: got %b want 0", en_ab_o); end
        tick();
        @(negedge clk_i);
        checks++; if (p0_rvalid_o !== 1'b0) begin errors++; $display("FAIL store_rvalid_early: got %b want 0", p0_rvalid_o); end
        tick();
        r_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (p0_rvalid_o !== 1'b1 || p0_rdata_o !== 32'hCAFE_0001 || p1_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL store_resp: got rvalid %b rdata %h p1 %b want 1 cafe0001 0", p0_rvalid_o, p0_rdata_o, p1_rvalid_o);
        end
        tick();
        @(negedge clk_i);
        checks++; if (p0_rvalid_o !== 1'b0) begin errors++; $display("FAIL store_rvalid_len: got %b want 0", p0_rvalid_o); end
        tick();
    endtask

    task automatic test_lim_and;
        p0_addr_i = 8'hEE; p0_mask_i = 32'hFFFF_FFFF; p0_funct_i = FUNCT_OR; p0_be_i = 4'hF;
        p1_addr_i = 8'h04; p1_mask_i = 32'h8D; p1_funct_i = FUNCT_AND; p1_be_i = 4'h1; p1_we_i = 1'b0;
        p1_req_i = 1'b1;
        @(negedge clk_i);
        checks++; if (p1_gnt_o !== 1'b1 || p0_gnt_o !== 1'b0) begin
            errors++; $display("FAIL lim_gnt: got gnt1 %b gnt0 %b want 1 0", p1_gnt_o, p0_gnt_o);
        end
        tick();
        p1_req_i = 1'b0;
        @(negedge clk_i);
        checks++; if (en_ab_o !== 1'b1 || funct_o !== 8'd2 || mask_o !== 32'h8D || be_b_o !== 4'h1 || ADDR_o !== 8'h04) begin
            errors++; $display("FAIL lim_issue: got en %b funct %h mask %h be %h addr %h want 1 02 0000008d 1 04",
                               en_ab_o, funct_o, mask_o, be_b_o, ADDR_o);
        end
        tick();
        tick();
        r_data_i = 32'h0000_0085; r_valid_i = 1'b1;
        @(negedge clk_i);
        checks++; if (funct_o !== 8'd2 || mask_o !== 32'h8D || be_b_o !== 4'h1 || write_en_data_o !== 1'b0) begin
            errors++; $display("FAIL lim_hold: got funct %h mask %h be %h we %b want 02 0000008d 1 0",
                               funct_o, mask_o, be_b_o, write_en_data_o);
        end
        tick();
        r_valid_i = 1'b0;
        tick();
        @(negedge clk_i);
        checks++; if (p1_rvalid_o !== 1'b1 || p1_rdata_o !== 32'h85 || p0_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL lim_resp: got rvalid1 %b rdata %h rvalid0 %b want 1 00000085 0", p1_rvalid_o, p1_rdata_o, p0_rvalid_o);
        end
        tick();
    endtask

    task automatic test_be_zero;
        p0_addr_i = 8'h33; p0_be_i = 4'h0; p0_we_i = 1'b0;
        r_data_i = 32'hFFFF_FFFF;
        p0_req_i = 1'b1;
        @(negedge clk_i);
        checks++; if (p0_gnt_o !== 1'b1) begin errors++; $display("FAIL be0_gnt: got %b want 1", p0_gnt_o); end
        tick();
        p0_req_i = 1'b0;
        @(negedge clk_i);
        checks++; if (en_ab_o !== 1'b0 || p0_rvalid_o !== 1'b0) begin
            errors++; $display("FAIL be0_mid: got en_ab %b rvalid %b want 0 0", en_ab_o, p0_rvalid_o);
        end
        tick();
        @(negedge clk_i);
        checks++; if (p0_rvalid_o !== 1'b1 || p0_rdata_o !== 32'h0 || p0_err_o !== 1'b0 || en_ab_o !== 1'b0) begin
            errors++; $display("FAIL be0_resp: got rvalid %b rdata %h err %b en_ab %b want 1 0 0 0",
                               p0_rvalid_o, p0_rdata_o, p0_err_o, en_ab_o);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        bit seen;
        bit found;
        p0_addr_i = 8'h08; p0_be_i = 4'hF; p0_we_i = 1'b1; p0_wdata_i = 32'h77;
        p0_req_i = 1'b1;
        tick();
        p0_req_i = 1'b0;
        tick();
        @(negedge clk_i);
        #1 rst_i = 1'b1;
        #1;
        checks++; if (en_ab_o !== 1'b0 || ADDR_o !== 8'h00 || write_en_data_o !== 1'b0 || be_b_o !== 4'h0 || write_i_data_o !== 32'h0) begin
            errors++; $display("FAIL rstmid_outputs: got en %b addr %h we %b be %h wdata %h want all 0",
                               en_ab_o, ADDR_o, write_en_data_o, be_b_o, write_i_data_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        r_data_i = 32'hDEAD_BEEF; r_valid_i = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (p0_rvalid_o || p1_rvalid_o) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_orphan: got rvalid 1 want 0"); end
        tick();
        r_valid_i = 1'b0;
        p0_addr_i = 8'h0C; p0_we_i = 1'b0;
        p0_req_i = 1'b1;
        @(negedge clk_i);
        checks++; if (p0_gnt_o !== 1'b1) begin errors++; $display("FAIL rstmid_regnt: got %b want 1", p0_gnt_o); end
        tick();
        p0_req_i = 1'b0;
        tick();
        r_data_i = 32'h1234_5678; r_valid_i = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (p0_rvalid_o) begin found = 1'b1; break; end
        end
        checks++; if (!found || p0_rdata_o !== 32'h1234_5678) begin
            errors++; $display("FAIL rstmid_serve: got found %b rdata %h want 1 12345678", found, p0_rdata_o);
        end
        tick();
        r_valid_i = 1'b0;
        tick();
    endtask

`ifdef LIM_SEQ_TIMEOUT_EN
    task automatic test_timeout;
        int wait_n;
        bit seen;
        p0_addr_i = 8'h40; p0_be_i = 4'hF; p0_we_i = 1'b0;
        r_valid_i = 1'b0;
        p0_req_i = 1'b1;
        tick();
        p0_req_i = 1'b0;
        wait_n = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            @(negedge clk_i);
            if (p0_rvalid_o) begin wait_n = c; break; end
        end
        // ISSUE, 8 WAIT cycles, RESP, then the strobe.
        checks++; if (wait_n != 10) begin errors++; $display("FAIL timeout_latency: got %0d want 10", wait_n); end
        checks++; if (p0_err_o !== 1'b1 || p0_rdata_o !== 32'h0) begin
            errors++; $display("FAIL timeout_err: got err %b rdata %h want 1 0", p0_err_o, p0_rdata_o);
        end
        tick();
        r_data_i = 32'hBAD0_0000; r_valid_i = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (p0_rvalid_o) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL timeout_late_edge: got rvalid 1 want 0"); end
        r_valid_i = 1'b0;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        p0_req_i = 1'b0; p1_req_i = 1'b0;
        p0_addr_i = '0; p0_we_i = 1'b0; p0_be_i = '0; p0_wdata_i = '0; p0_mask_i = '0; p0_funct_i = '0;
        p1_addr_i = '0; p1_we_i = 1'b0; p1_be_i = '0; p1_wdata_i = '0; p1_mask_i = '0; p1_funct_i = '0;
        r_data_i = '0; r_valid_i = 1'b0;
        test_reset();
        test_back_to_back();
        test_single_store();
        test_lim_and();
        test_be_zero();
        test_reset_mid();
`ifdef LIM_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
